// File: rtl/cpu_pkg.sv
// Shared types and helpers for the load/store unit of the RV32I core.
//
// Contents:
//   LSU_B/H/W/BU/HU : RV32I funct3 encodings of the supported access sizes
//   lsu_state_t     : LSU transaction state (IDLE, REQ, WAIT, DONE)
//   lsu_err_t       : fault cause reported on lsu_err_cause
//   lsu_extend      : zero/sign extension of a load lane already shifted to bit 0
package cpu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_ILLEGAL  = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } lsu_err_t;

    // lane holds the addressed byte/halfword in its low bits.
    function automatic logic [31:0] lsu_extend(input logic [2:0]  funct3,
                                               input logic [31:0] lane);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [31:0]        res;
        byte_s = lane[7:0];
        half_s = lane[15:0];
        case (funct3)
            LSU_B:   res = {{24{byte_s[7]}}, byte_s};
            LSU_H:   res = {{16{half_s[15]}}, half_s};
            LSU_BU:  res = {24'h000000, lane[7:0]};
            LSU_HU:  res = {16'h0000, lane[15:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//
// Request side (current instruction):
//   funct3_i, addr_lo_i, we_i, wdata_i -> illegal_o, misalign_o, be_o, wdata_o
//   Store data is replicated across every lane of its size so the memory
//   only has to honour the byte enables. Loads drive be_o/wdata_o to zero.
// Response side (registered load context):
//   ld_funct3_i, ld_addr_lo_i, ld_word_i -> ld_data_o (aligned, extended)
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_word_i,
    output logic        illegal_o,
    output logic        misalign_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_lane;

    always_comb begin
        illegal_o  = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
        misalign_o = 1'b0;
        be_o       = 4'b0000;
        wdata_o    = 32'h0000_0000;
        // funct3[1:0] is the access size; bit 2 only selects load signedness.
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                misalign_o = |addr_lo_i;
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
            end
            default: begin
            end
        endcase
        if (!we_i) begin
            be_o    = 4'b0000;
            wdata_o = 32'h0000_0000;
        end
    end

    always_comb begin
        ld_lane   = ld_word_i >> {ld_addr_lo_i, 3'b000};
        ld_data_o = lsu_extend(ld_funct3_i, ld_lane);
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit placed after the ALU of the single-stage RV32I core.
//
// Runs one request/grant/response transaction on the data-memory port per
// load or store, stalling the core until the access retires.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   lsu_valid           current instruction is a load or store
//   lsu_we              1 = store, 0 = load
//   lsu_funct3          RV32I size/signedness encoding
//   lsu_addr            effective address (ALU result)
//   lsu_wdata           store data (rs2)
//   lsu_stall           hold PC/instruction (combinational)
//   lsu_done            one-cycle pulse when the access retires
//   lsu_rdata           extended load data, held until the next load retires
//   lsu_err             one-cycle fault pulse
//   lsu_err_cause       fault cause (lsu_err_t), valid with lsu_err
//   dmem_req/we/addr/be/wdata   registered bus request fields
//   dmem_gnt            request accepted (only meaningful in REQ)
//   dmem_rvalid/rdata   load response (only meaningful in WAIT)
//
// Parameter TIMEOUT: cycles allowed in REQ or WAIT before the access is
// abandoned with ERR_TIMEOUT; 0 disables the watchdog.
module lsu_mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic [1:0]  lsu_err_cause,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              dmem_req_q;
    logic              dmem_we_q;
    logic [31:0]       dmem_addr_q;
    logic [3:0]        dmem_be_q;
    logic [31:0]       dmem_wdata_q;
    logic [2:0]        ld_funct3_q;
    logic [1:0]        ld_off_q;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic              err_q;
    lsu_err_t          cause_q;

    logic              al_illegal;
    logic              al_misalign;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_ld_data;

    logic              fault_any;
    logic              idle_fault;
    logic              timeout_hit;

    lsu_align u_align (
        .funct3_i     (lsu_funct3),
        .addr_lo_i    (lsu_addr[1:0]),
        .we_i         (lsu_we),
        .wdata_i      (lsu_wdata),
        .ld_funct3_i  (ld_funct3_q),
        .ld_addr_lo_i (ld_off_q),
        .ld_word_i    (dmem_rdata),
        .illegal_o    (al_illegal),
        .misalign_o   (al_misalign),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .ld_data_o    (al_ld_data)
    );

    assign fault_any   = al_illegal | al_misalign;
    // Faults are reported in the issue cycle itself so the core never stalls on them.
    assign idle_fault  = (state_q == IDLE) && lsu_valid && fault_any;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    assign lsu_stall     = lsu_valid && (state_q != DONE) && !idle_fault;
    assign lsu_done      = done_q;
    assign lsu_rdata     = rdata_q;
    assign lsu_err       = idle_fault | err_q;
    assign lsu_err_cause = idle_fault ? (al_illegal ? ERR_ILLEGAL : ERR_MISALIGN) : cause_q;
    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_be       = dmem_be_q;
    assign dmem_wdata    = dmem_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0000_0000;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= 32'h0000_0000;
            ld_funct3_q  <= 3'b000;
            ld_off_q     <= 2'b00;
            rdata_q      <= 32'h0000_0000;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cause_q      <= ERR_NONE;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cause_q <= ERR_NONE;
            case (state_q)
                IDLE: begin
                    if (lsu_valid && !fault_any) begin
                        state_q      <= REQ;
                        cnt_q        <= '0;
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= lsu_we;
                        dmem_addr_q  <= {lsu_addr[31:2], 2'b00};
                        dmem_be_q    <= al_be;
                        dmem_wdata_q <= al_wdata;
                        ld_funct3_q  <= lsu_funct3;
                        ld_off_q     <= lsu_addr[1:0];
                    end
                end
                REQ: begin
                    // A grant in the last allowed cycle still wins over the timeout.
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        cnt_q      <= '0;
                        if (dmem_we_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (timeout_hit) begin
                        dmem_req_q <= 1'b0;
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        cause_q    <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        rdata_q <= al_ld_data;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        cause_q <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a per-cycle reference model.
module tb_lsu_mem_stage;

    localparam int TMO = 16;

    logic        clk;
    logic        rst_n;
    logic        lsu_valid;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic [1:0]  lsu_err_cause;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    lsu_mem_stage #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lsu_valid     (lsu_valid),
        .lsu_we        (lsu_we),
        .lsu_funct3    (lsu_funct3),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_stall     (lsu_stall),
        .lsu_done      (lsu_done),
        .lsu_rdata     (lsu_rdata),
        .lsu_err       (lsu_err),
        .lsu_err_cause (lsu_err_cause),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Expected outputs for the current cycle.
    bit          chk_on = 1'b0;
    logic        exp_stall, exp_done, exp_err, exp_req, exp_we;
    logic [1:0]  exp_cause;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    // Observations captured at the sampling edge for literal checks.
    int          req_cycles;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic [1:0]  cap_cause;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---- reference rules -------------------------------------------------
    function automatic int m_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] m_cause(input logic [2:0] f3, input logic [31:0] a);
        int off;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 2'd2;
        off = int'(a % 4);
        if ((off % m_bytes(f3)) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int nb;
        nb = m_bytes(f3);
        return 4'(((1 << nb) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        int nb;
        nb = m_bytes(f3);
        if (nb == 1) return (w % 256) * 32'h0101_0101;
        if (nb == 2) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        longint v;
        longint span;
        int     nb;
        nb = m_bytes(f3);
        v  = longint'(w) >> (8 * (a % 4));
        if (nb < 4) begin
            span = longint'(1) << (8 * nb);
            v    = v % span;
            if (f3 < 3'b100 && v >= span / 2) v = v - span;
        end
        return v[31:0];
    endfunction

    // ---- per-cycle comparison and capture -------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("stall", 32'(lsu_stall), 32'(exp_stall));
                chk("done", 32'(lsu_done), 32'(exp_done));
                chk("err", 32'(lsu_err), 32'(exp_err));
                chk("dmem_req", 32'(dmem_req), 32'(exp_req));
                chk("rdata", lsu_rdata, exp_rdata);
                if (exp_err) chk("cause", 32'(lsu_err_cause), 32'(exp_cause));
                if (exp_req) begin
                    chk("dmem_we", 32'(dmem_we), 32'(exp_we));
                    chk("dmem_addr", dmem_addr, exp_addr);
                    chk("dmem_be", 32'(dmem_be), 32'(exp_be));
                    if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end
            if (dmem_req) begin
                if (req_cycles == 0) begin
                    cap_addr  = dmem_addr;
                    cap_be    = dmem_be;
                    cap_wdata = dmem_wdata;
                end
                req_cycles++;
            end
            if (lsu_err) cap_cause = lsu_err_cause;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_stall = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_cause = 2'd0;
        exp_req   = 1'b0;
    endtask

    // gnt_dly / rv_dly: cycles of REQ / WAIT before the bus answers (-1 = never).
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                           input logic [31:0] rword, input bit drop_valid);
        logic [1:0] cause;
        bit         tmo;
        int         k;
        cause      = m_cause(f3, a);
        tmo        = 1'b0;
        req_cycles = 0;
        cap_cause  = 2'd0;

        // Issue cycle; a stale rvalid here must be ignored.
        lsu_valid   = 1'b1;
        lsu_we      = we;
        lsu_funct3  = f3;
        lsu_addr    = a;
        lsu_wdata   = wd;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        set_idle_exp();
        exp_stall = (cause == 2'd0);
        exp_err   = (cause != 2'd0);
        exp_cause = cause;
        step();

        if (cause == 2'd0) begin
            if (drop_valid) lsu_valid = 1'b0;
            k = 0;
            forever begin
                exp_req     = 1'b1;
                exp_we      = we;
                exp_addr    = a - (a % 4);
                exp_be      = we ? m_be(f3, a) : 4'b0000;
                exp_wdata   = m_wdata(f3, wd);
                exp_stall   = lsu_valid;
                exp_err     = 1'b0;
                exp_done    = 1'b0;
                dmem_gnt    = (k == gnt_dly);
                dmem_rvalid = 1'b1;
                dmem_rdata  = ~rword;
                step();
                if (k == gnt_dly) break;
                if (k == TMO - 1) begin
                    tmo = 1'b1;
                    break;
                end
                k++;
            end
            exp_req = 1'b0;
            if (!we && !tmo) begin
                k = 0;
                forever begin
                    exp_stall   = lsu_valid;
                    dmem_gnt    = 1'b1;
                    dmem_rvalid = (k == rv_dly);
                    dmem_rdata  = rword;
                    step();
                    if (k == rv_dly) begin
                        exp_rdata = m_load(f3, a, rword);
                        break;
                    end
                    if (k == TMO - 1) begin
                        tmo = 1'b1;
                        break;
                    end
                    k++;
                end
            end
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            exp_stall   = 1'b0;
            exp_done    = 1'b1;
            exp_err     = tmo;
            exp_cause   = tmo ? 2'd3 : 2'd0;
            step();
        end

        // Idle cycle with bus noise that must be ignored.
        lsu_valid   = 1'b0;
        set_idle_exp();
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5A5A_5A5A;
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        lsu_valid   = 1'b0;
        lsu_we      = 1'b0;
        lsu_funct3  = 3'b000;
        lsu_addr    = 32'h0;
        lsu_wdata   = 32'h0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        req_cycles  = 0;
        cap_addr    = 32'h0;
        cap_be      = 4'h0;
        cap_wdata   = 32'h0;
        cap_cause   = 2'd0;
        exp_rdata   = 32'h0;
        exp_we      = 1'b0;
        exp_addr    = 32'h0;
        exp_be      = 4'h0;
        exp_wdata   = 32'h0;
        set_idle_exp();

        #12;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_we", 32'(dmem_we), 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_be", 32'(dmem_be), 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_rdata", lsu_rdata, 32'h0);
        chk("rst_done", 32'(lsu_done), 32'h0);
        chk("rst_err", 32'(lsu_err), 32'h0);
        chk("rst_cause", 32'(lsu_err_cause), 32'h0);
        chk("rst_stall", 32'(lsu_stall), 32'h0);
        rst_n = 1'b1;
        step();
        chk_on = 1'b1;

        // SB with immediate grant
        run_txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0, 1'b0);
        chk("sb_addr", cap_addr, 32'h0000_1000);
        chk("sb_be", 32'(cap_be), 32'h8);
        chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        chk("sb_req_cycles", 32'(req_cycles), 32'd1);

        // Load extraction
        run_txn(1'b0, 3'b000, 32'h0000_2001, 32'h0, 0, 0, 32'h0000_80FF, 1'b0);
        chk("lb_rdata", lsu_rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 3'b100, 32'h0000_2001, 32'h0, 0, 0, 32'h0000_80FF, 1'b0);
        chk("lbu_rdata", lsu_rdata, 32'h0000_0080);
        run_txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 1, 2, 32'h8001_0000, 1'b0);
        chk("lh_rdata", lsu_rdata, 32'hFFFF_8001);
        run_txn(1'b0, 3'b000, 32'h0000_2003, 32'h0, 0, 0, 32'h7F00_0000, 1'b0);
        chk("lb_pos_rdata", lsu_rdata, 32'h0000_007F);

        // Issue-cycle faults
        run_txn(1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 0, 32'h0, 1'b0);
        chk("lw_mis_cause", 32'(cap_cause), 32'd1);
        chk("lw_mis_noreq", 32'(req_cycles), 32'd0);
        run_txn(1'b0, 3'b011, 32'h0000_3000, 32'h0, 0, 0, 32'h0, 1'b0);
        chk("ill_cause", 32'(cap_cause), 32'd2);
        run_txn(1'b1, 3'b001, 32'h0000_6001, 32'h0, 0, 0, 32'h0, 1'b0);
        chk("sh_mis_cause", 32'(cap_cause), 32'd1);
        run_txn(1'b1, 3'b111, 32'h0000_6000, 32'h0, 0, 0, 32'h0, 1'b0);
        chk("ill7_cause", 32'(cap_cause), 32'd2);

        // SW with delayed grant
        run_txn(1'b1, 3'b010, 32'h0000_3004, 32'hCAFE_BABE, 4, 0, 32'h0, 1'b0);
        chk("sw_req_cycles", 32'(req_cycles), 32'd5);
        chk("sw_be", 32'(cap_be), 32'hF);

        // lsu_valid dropped mid-transaction
        run_txn(1'b0, 3'b101, 32'h0000_5002, 32'h0, 2, 1, 32'hBEEF_0000, 1'b1);
        chk("lhu_drop_rdata", lsu_rdata, 32'h0000_BEEF);

        // SH / SB lane placement
        run_txn(1'b1, 3'b001, 32'h0000_6002, 32'h1234_ABCD, 0, 0, 32'h0, 1'b0);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        run_txn(1'b1, 3'b000, 32'h0000_6000, 32'h0000_0011, 1, 0, 32'h0, 1'b0);
        chk("sb0_be", 32'(cap_be), 32'h1);

        // Timeouts
        run_txn(1'b0, 3'b010, 32'h0000_4000, 32'h0, 1, 1, 32'h1234_5678, 1'b0);
        chk("lw_rdata", lsu_rdata, 32'h1234_5678);
        run_txn(1'b0, 3'b010, 32'h0000_4004, 32'h0, 0, -1, 32'h0, 1'b0);
        chk("tmo_wait_cause", 32'(cap_cause), 32'd3);
        chk("tmo_wait_rdata", lsu_rdata, 32'h1234_5678);
        run_txn(1'b1, 3'b010, 32'h0000_4008, 32'h0, -1, 0, 32'h0, 1'b0);
        chk("tmo_req_cycles", 32'(req_cycles), 32'd16);
        chk("tmo_req_cause", 32'(cap_cause), 32'd3);

        // Reset while waiting for load data
        lsu_valid   = 1'b1;
        lsu_we      = 1'b0;
        lsu_funct3  = 3'b010;
        lsu_addr    = 32'h0000_7000;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        set_idle_exp();
        exp_stall = 1'b1;
        step();
        exp_req  = 1'b1;
        exp_we   = 1'b0;
        exp_addr = 32'h0000_7000;
        exp_be   = 4'b0000;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        exp_req  = 1'b0;
        step();
        chk_on    = 1'b0;
        lsu_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(dmem_req), 32'h0);
        chk("mid_rst_done", 32'(lsu_done), 32'h0);
        chk("mid_rst_err", 32'(lsu_err), 32'h0);
        chk("mid_rst_stall", 32'(lsu_stall), 32'h0);
        chk("mid_rst_rdata", lsu_rdata, 32'h0);
        #2;
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        step();
        step();
        exp_rdata = 32'h0;
        set_idle_exp();
        chk_on = 1'b1;
        step();
        dmem_rvalid = 1'b0;
        chk("stale_rvalid_rdata", lsu_rdata, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU in the RV32I single-stage core.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs a multi-cycle request/grant/response transaction on the data-memory port, stalling the core until the access completes.
- Produces aligned, sign- or zero-extended load data for writeback, and flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, default 16: maximum cycles spent waiting in REQ or WAIT before a bus error is raised. 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- lsu_valid  in  1  current instruction is a load or store
- lsu_we  in  1  1 = store, 0 = load
- lsu_funct3  in  3  access size and signedness (RV32I funct3 encoding)
- lsu_addr  in  32  effective address (ALU result)
- lsu_wdata  in  32  store data (rs2)
- lsu_stall  out  1  hold PC and instruction (combinational)
- lsu_done  out  1  one-cycle pulse: access complete
- lsu_rdata  out  32  extended load data, held until the next load completes
- lsu_err  out  1  one-cycle pulse: access faulted
- lsu_err_cause  out  2  fault cause, valid while lsu_err is high
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write enable
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data word

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset: state IDLE, counter 0. All registered outputs are 0: dmem_req/we/addr/be/wdata, lsu_rdata, lsu_done, lsu_err, lsu_err_cause.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, lsu_valid high:
  - Illegal funct3 (011, 110, 111): lsu_err=1, cause ILLEGAL.
  - Misaligned access (H with addr[0]=1, W with addr[1:0]≠0): lsu_err=1, cause MISALIGN.
  - In both fault cases: lsu_stall=0, no bus activity, stay in IDLE.
  - Otherwise: register the bus fields, go to REQ, lsu_stall=1.
- REQ:
  - dmem_req=1; addr, we, be and wdata held stable until dmem_gnt.
  - On gnt, dmem_req drops the next cycle. A store goes to DONE; a load goes to WAIT.
- WAIT:
  - dmem_rvalid is honoured only from the cycle after gnt.
  - On rvalid: extract the addressed lane, extend it, register it into lsu_rdata, go to DONE.
- DONE: lsu_done=1 and lsu_stall=0 for exactly one cycle (the core retires), then IDLE.
- lsu_stall = lsu_valid & (state≠DONE) & ~(IDLE fault).
- Timeout: a counter increments in REQ and WAIT and clears on state entry. When it reaches TIMEOUT:
  - lsu_err=1, cause TIMEOUT, dmem_req drops, go to DONE.
  - lsu_done is still pulsed; lsu_rdata is left unchanged.
- Minimum latency: store 3 cycles (IDLE→REQ→DONE, gnt in the first REQ cycle); load 4 cycles.
- Store lane rules:
  - SB: byte replicated ×4, be = 1<<addr[1:0].
  - SH: halfword replicated ×2, be = 0011 or 1100.
  - SW: be = 1111.
  - dmem_be = 0 on loads.
- Load extraction:
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - The lane is selected by addr[1:0].
  - LW passes the word through.
- lsu_valid deasserting mid-transaction: the transaction still completes (the bus cannot abort); done is still pulsed.
- rvalid in IDLE or REQ, or gnt outside REQ: ignored.
- Reset mid-operation: immediately returns to IDLE with dmem_req=0. Stale rvalid after reset is ignored.

Decomposition:
- cpu_pkg:
  - LSU_B=000, LSU_H=001, LSU_W=010, LSU_BU=100, LSU_HU=101.
  - lsu_state_t {IDLE, REQ, WAIT, DONE}.
  - lsu_err_t {ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT}.
- Sub-module lsu_align (combinational): misalign/illegal detection, dmem_be/dmem_wdata generation, load lane extraction and extension.

Test Plan:
- SB, addr 0x1003, wdata 0x000000AB, gnt in the first REQ cycle -> dmem_addr 0x1000, be 1000, wdata 0xABABABAB, lsu_done 2 cycles after accept, stall high for 2 cycles.
- LB, addr 0x2001, rdata 0x000080FF -> lsu_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x2002, rdata 0x8001_0000 -> 0xFFFF8001.
- LW, addr 0x3002 -> lsu_err=1, cause MISALIGN, same cycle; dmem_req never asserted; lsu_stall=0. funct3=011 -> cause ILLEGAL.
- SW, gnt delayed 5 cycles -> dmem_req held with stable addr/be/wdata for 5 cycles, lsu_stall high throughout, done one cycle after gnt.
- TIMEOUT=16, load granted but no rvalid -> lsu_err cause TIMEOUT after 16 WAIT cycles, lsu_done pulses, lsu_rdata keeps its previous value.
- rst_n low during WAIT -> dmem_req/lsu_done/lsu_err 0 immediately, state IDLE; a later rvalid does not change lsu_rdata.
